// File: rtl/fp_fma_dot_sequencer_if.sv
// fp_fma_dot_sequencer_if: job control, operand stream, FMA link and result port of the dot-product sequencer
interface fp_fma_dot_sequencer_if #(
    parameter int exp_width = 8,
    parameter int frac_width = 23,
    parameter int len_width = 8
);
    logic                               start;
    logic [len_width-1:0]               vec_len;
    logic [exp_width+frac_width:0]      acc_init;
    logic [1:0]                         round_mode;
    logic                               in_valid;
    logic [exp_width+frac_width:0]      in_a;
    logic [exp_width+frac_width:0]      in_b;
    logic                               in_ready;
    logic [exp_width+frac_width:0]      fma_op1;
    logic [exp_width+frac_width:0]      fma_op2;
    logic [exp_width+frac_width:0]      fma_op_acc;
    logic [1:0]                         fma_round_mode;
    logic [exp_width+frac_width:0]      fma_result;
    logic [4:0]                         fma_exception;
    logic                               out_valid;
    logic                               out_ready;
    logic [exp_width+frac_width:0]      out_result;
    logic [4:0]                         out_exception;
    logic                               busy;

    modport slave (
        input  start, vec_len, acc_init, round_mode, in_valid, in_a, in_b,
               fma_result, fma_exception, out_ready,
        output in_ready, fma_op1, fma_op2, fma_op_acc, fma_round_mode,
               out_valid, out_result, out_exception, busy
    );

    modport master (
        output start, vec_len, acc_init, round_mode, in_valid, in_a, in_b,
               fma_result, fma_exception, out_ready,
        input  in_ready, fma_op1, fma_op2, fma_op_acc, fma_round_mode,
               out_valid, out_result, out_exception, busy
    );
endinterface

// File: rtl/fp_fma_dot_sequencer.sv
// fp_fma_dot_sequencer: accumulates a dot product by streaming operand pairs through an external combinational FMA
module fp_fma_dot_sequencer #(
    parameter int exp_width = 8,
    parameter int frac_width = 23,
    parameter int len_width = 8
) (
    input logic                    clk,
    input logic                    reset,
    fp_fma_dot_sequencer_if.slave  bus
);
    localparam int fw = exp_width + frac_width + 1;

    typedef enum logic [1:0] {idle, accum, done} state_t;

    state_t               state, state_nx;
    logic [fw-1:0]        acc;
    logic [4:0]           flags;
    logic [len_width-1:0] remaining;
    logic [1:0]           rmode;
    logic                 load, fire, last;

    assign load = state == idle && bus.start;
    assign fire = state == accum && bus.in_valid;
    assign last = remaining == len_width'(1);

    assign bus.fma_op1        = bus.in_a;
    assign bus.fma_op2        = bus.in_b;
    assign bus.fma_op_acc     = acc;
    assign bus.fma_round_mode = rmode;
    assign bus.out_result     = acc;
    assign bus.out_exception  = flags;

    // state register; reset discards any job in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= idle;
        else       state <= state_nx;
    end

    // next state and handshake outputs; a zero-length job goes straight to done
    always_comb begin
        state_nx      = state;
        bus.in_ready  = state == accum;
        bus.out_valid = state == done;
        bus.busy      = state != idle;
        if (load) state_nx = bus.vec_len != '0 ? accum : done;
        if (fire && last) state_nx = done;
        if (state == done && bus.out_ready) state_nx = idle;
    end

    // job context: load on start, fold each accepted FMA beat into acc and sticky flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            flags     <= '0;
            remaining <= '0;
            rmode     <= '0;
        end else if (load) begin
            acc       <= bus.acc_init;
            flags     <= '0;
            remaining <= bus.vec_len;
            rmode     <= bus.round_mode;
        end else if (fire) begin
            acc       <= bus.fma_result;
            flags     <= flags | bus.fma_exception;
            remaining <= remaining - len_width'(1);
        end
    end
endmodule

// File: tb/tb_fp_fma_dot_sequencer.sv
// tb_fp_fma_dot_sequencer: directed checks of the dot-product sequencer against a table-driven FMA stand-in
module tb_fp_fma_dot_sequencer;
    logic clk = 0;
    logic reset = 1;
    int tests = 0;
    int fails = 0;
    logic [31:0] va [0:3];
    logic [31:0] vb [0:3];

    fp_fma_dot_sequencer_if bus ();

    fp_fma_dot_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // FMA stand-in: hand-computed a*b+acc for the vectors used; anything else yields qNaN with invalid
    always_comb begin
        bus.fma_result    = 32'h7FC00000;
        bus.fma_exception = 5'b10000;
        case ({bus.fma_op1, bus.fma_op2, bus.fma_op_acc})
            {32'h3F800000, 32'h3F800000, 32'h00000000}: begin bus.fma_result = 32'h3F800000; bus.fma_exception = 5'b00000; end
            {32'h40000000, 32'h40000000, 32'h3F800000}: begin bus.fma_result = 32'h40A00000; bus.fma_exception = 5'b00000; end
            {32'h40400000, 32'h40400000, 32'h40A00000}: begin bus.fma_result = 32'h41600000; bus.fma_exception = 5'b00000; end
            {32'h7F7FFFFF, 32'h40000000, 32'h00000000}: begin bus.fma_result = 32'h7F800000; bus.fma_exception = 5'b00101; end
            {32'h3F800000, 32'h3F800000, 32'h7F800000}: begin bus.fma_result = 32'h7F800000; bus.fma_exception = 5'b00000; end
            default: ;
        endcase
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic load_basic();
        va[0] = 32'h3F800000; vb[0] = 32'h3F800000;
        va[1] = 32'h40000000; vb[1] = 32'h40000000;
        va[2] = 32'h40400000; vb[2] = 32'h40400000;
    endtask

    task automatic start_job(input logic [7:0] len, input logic [31:0] init, input logic [1:0] rm);
        bus.start = 1; bus.vec_len = len; bus.acc_init = init; bus.round_mode = rm;
        @(posedge clk); #1;
        bus.start = 0; bus.vec_len = 8'd77; bus.acc_init = 32'hDEADBEEF; bus.round_mode = 2'd1;
    endtask

    task automatic feed(input int n, input bit bub, input int pulse_at, output int cyc);
        int i = 0;
        bit hs;
        cyc = 0;
        while (i < n && cyc < 50) begin
            bus.in_valid = bub ? (cyc % 2 == 1) : 1'b1;
            bus.in_a = va[i];
            bus.in_b = vb[i];
            bus.start = cyc == pulse_at;
            if (cyc == pulse_at) begin bus.vec_len = 8'd1; bus.acc_init = 32'h40400000; end
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) i++;
        end
        bus.in_valid = 0;
        bus.start = 0;
        tests++;
        if (i !== n) begin fails++; $display("FAIL feed_beats: accepted %0d want %0d", i, n); end
    endtask

    task automatic retire();
        bus.out_ready = 1;
        @(posedge clk); #1;
        bus.out_ready = 0;
        tests++;
        if (bus.busy !== 1'b0) begin fails++; $display("FAIL retire_idle: busy %b want 0", bus.busy); end
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        tests++; if (bus.out_result !== 32'h0) begin fails++; $display("FAIL reset_result: got %h want 00000000", bus.out_result); end
        tests++; if (bus.out_exception !== 5'h0) begin fails++; $display("FAIL reset_exc: got %b want 00000", bus.out_exception); end
        tests++; if (bus.fma_round_mode !== 2'd0) begin fails++; $display("FAIL reset_rmode: got %0d want 0", bus.fma_round_mode); end
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int cyc;
        load_basic();
        start_job(8'd3, 32'h0, 2'd3);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL basic_in_ready: got %b want 1", bus.in_ready); end
        tests++; if (bus.fma_round_mode !== 2'd3) begin fails++; $display("FAIL basic_rmode: got %0d want 3", bus.fma_round_mode); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", bus.out_valid); end
        feed(3, 0, -1, cyc);
        tests++; if (cyc + 1 !== 4) begin fails++; $display("FAIL basic_latency: got %0d want 4", cyc + 1); end
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid: got %b want 1", bus.out_valid); end
        tests++; if (bus.out_result !== 32'h41600000) begin fails++; $display("FAIL basic_result: got %h want 41600000", bus.out_result); end
        tests++; if (bus.out_exception !== 5'h0) begin fails++; $display("FAIL basic_exc: got %b want 00000", bus.out_exception); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL basic_done_ready: got %b want 0", bus.in_ready); end
        retire();
    endtask

    task automatic test_bubbles_backpressure();
        int cyc;
        load_basic();
        start_job(8'd3, 32'h0, 2'd0);
        feed(3, 1, -1, cyc);
        tests++; if (cyc !== 6) begin fails++; $display("FAIL bubble_cycles: got %0d want 6", cyc); end
        bus.in_valid = 1; bus.in_a = 32'h3F800000; bus.in_b = 32'h3F800000;
        for (int k = 0; k < 5; k++) begin
            tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d]: got %b want 1", k, bus.out_valid); end
            tests++; if (bus.out_result !== 32'h41600000) begin fails++; $display("FAIL hold_result[%0d]: got %h want 41600000", k, bus.out_result); end
            tests++; if (bus.out_exception !== 5'h0) begin fails++; $display("FAIL hold_exc[%0d]: got %b want 00000", k, bus.out_exception); end
            tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL hold_in_ready[%0d]: got %b want 0", k, bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        bus.out_ready = 1; bus.start = 1; bus.vec_len = 8'd2; bus.acc_init = 32'h0;
        @(posedge clk); #1;
        bus.out_ready = 0; bus.start = 0;
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL done_start_ignored: busy %b want 0", bus.busy); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL done_release: out_valid %b want 0", bus.out_valid); end
    endtask

    task automatic test_sticky_overflow();
        int cyc;
        va[0] = 32'h7F7FFFFF; vb[0] = 32'h40000000;
        va[1] = 32'h3F800000; vb[1] = 32'h3F800000;
        start_job(8'd2, 32'h0, 2'd0);
        feed(2, 0, -1, cyc);
        tests++; if (bus.out_result !== 32'h7F800000) begin fails++; $display("FAIL ovf_result: got %h want 7f800000", bus.out_result); end
        tests++; if (bus.out_exception[2] !== 1'b1) begin fails++; $display("FAIL ovf_sticky_bit: got %b want 1", bus.out_exception[2]); end
        tests++; if (bus.out_exception !== 5'b00101) begin fails++; $display("FAIL ovf_flags: got %b want 00101", bus.out_exception); end
        retire();
    endtask

    task automatic test_zero_length();
        start_job(8'd0, 32'h40A00000, 2'd2);
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL zero_out_valid: got %b want 1", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL zero_in_ready: got %b want 0", bus.in_ready); end
        tests++; if (bus.out_result !== 32'h40A00000) begin fails++; $display("FAIL zero_result: got %h want 40a00000", bus.out_result); end
        tests++; if (bus.out_exception !== 5'h0) begin fails++; $display("FAIL zero_exc: got %b want 00000", bus.out_exception); end
        retire();
    endtask

    task automatic test_start_ignored();
        int cyc;
        load_basic();
        start_job(8'd3, 32'h0, 2'd0);
        feed(3, 0, 1, cyc);
        tests++; if (cyc !== 3) begin fails++; $display("FAIL busy_start_cycles: got %0d want 3", cyc); end
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL busy_start_valid: got %b want 1", bus.out_valid); end
        tests++; if (bus.out_result !== 32'h41600000) begin fails++; $display("FAIL busy_start_result: got %h want 41600000", bus.out_result); end
        retire();
    endtask

    task automatic test_reset_mid_job();
        int cyc;
        load_basic();
        start_job(8'd3, 32'h0, 2'd2);
        feed(1, 0, -1, cyc);
        tests++; if (bus.out_result !== 32'h3F800000) begin fails++; $display("FAIL mid_partial_acc: got %h want 3f800000", bus.out_result); end
        #2 reset = 1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
        tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL mid_busy: got %b want 0", bus.busy); end
        tests++; if (bus.out_result !== 32'h0) begin fails++; $display("FAIL mid_acc: got %h want 00000000", bus.out_result); end
        tests++; if (bus.out_exception !== 5'h0) begin fails++; $display("FAIL mid_flags: got %b want 00000", bus.out_exception); end
        tests++; if (bus.fma_round_mode !== 2'd0) begin fails++; $display("FAIL mid_rmode: got %0d want 0", bus.fma_round_mode); end
        #1 reset = 0;
        @(posedge clk); #1;
        start_job(8'd3, 32'h0, 2'd0);
        feed(3, 0, -1, cyc);
        tests++; if (bus.out_result !== 32'h41600000) begin fails++; $display("FAIL mid_fresh_result: got %h want 41600000", bus.out_result); end
        tests++; if (bus.out_exception !== 5'h0) begin fails++; $display("FAIL mid_fresh_exc: got %b want 00000", bus.out_exception); end
        retire();
    endtask

    initial begin
        bus.start = 0; bus.vec_len = 0; bus.acc_init = 0; bus.round_mode = 0;
        bus.in_valid = 0; bus.in_a = 0; bus.in_b = 0; bus.out_ready = 0;
        test_reset();
        test_basic();
        test_bubbles_backpressure();
        test_sticky_overflow();
        test_zero_length();
        test_start_ignored();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
